debug_tx_sequencer: RTL and testbench

Controller that drains the 32-bit debug transmit FIFO into the byte-wide UART transmitter. On a start request it pops words until the FIFO is empty and sends each as bytes, least-significant first, handshaking with the UART TX `start`/`done` pair. It sits between the debug-unit FIFO (pop side) and `uart_tx`, and owns the FIFO read enable exclusively.

---
 rtl/debug_tx_pkg.sv | 35 +++
 rtl/debug_tx_sequencer_if.sv | 21 ++
 rtl/debug_word_serializer.sv | 37 +++
 rtl/debug_tx_sequencer.sv | 131 +++++++++++++
 tb/tb_debug_tx_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_tx_pkg.sv
// Shared constants, state encoding and helpers for the debug TX sequencer.
// Optional framing is selected by defining DEBUG_TX_FRAMING_EN.
package debug_tx_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int BYTES_PER_WORD = DATA_WIDTH_DEF / 8;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_POP     = 3'd1;
  localparam logic [2:0] ST_SEND    = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_HEADER  = 3'd5;
  localparam logic [2:0] ST_TRAILER = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_POP     = ST_POP,
    S_SEND    = ST_SEND,
    S_WAIT    = ST_WAIT,
    S_DONE    = ST_DONE,
    S_HEADER  = ST_HEADER,
    S_TRAILER = ST_TRAILER
  } state_t;

  // Byte index width; a single-byte word still needs a 1-bit index.
  function automatic int idx_width(input int bytes_per_word);
    return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
  endfunction

  localparam int IDX_WIDTH = idx_width(BYTES_PER_WORD);

endpackage

// File: rtl/debug_tx_sequencer_if.sv
// FIFO pop side and UART TX handshake seen by the debug TX sequencer.
interface debug_tx_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  o_fifo_rd_en;
  logic [7:0]            o_tx_data;
  logic                  o_tx_start;
  logic                  i_tx_done;

  modport master (
    input  i_fifo_empty, i_fifo_data, i_tx_done,
    output o_fifo_rd_en, o_tx_data, o_tx_start
  );

  modport slave (
    output i_fifo_empty, i_fifo_data, i_tx_done,
    input  o_fifo_rd_en, o_tx_data, o_tx_start
  );
endinterface

// File: rtl/debug_word_serializer.sv
// Holds the popped FIFO word and presents it one byte at a time, LSB first.
module debug_word_serializer
  import debug_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic                  i_advance,
  input  logic [DATA_WIDTH-1:0] i_word,
  output logic [7:0]            o_byte,
  output logic                  o_last
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int IW  = idx_width(BPW);
  localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);

  logic [DATA_WIDTH-1:0] word_q;
  logic [IW-1:0]         idx_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (i_load) begin
      word_q <= i_word;
      idx_q  <= '0;
    end else if (i_advance && !o_last) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  assign o_byte = word_q[{idx_q, 3'b000} +: 8];
  assign o_last = (idx_q == LAST_IDX);

endmodule

// File: rtl/debug_tx_sequencer.sv
// Drains the debug TX FIFO into the UART transmitter, LSB byte first.
// Define DEBUG_TX_FRAMING_EN to wrap each dump in an A5 header and word-count trailer.
//
// state   | meaning
// IDLE    | waiting for i_start
// POP     | pop a word if the FIFO has one, else finish the dump
// SEND    | o_tx_start strobe for the current byte
// WAIT    | holding the byte until the UART reports done
// DONE    | o_done pulse, back to IDLE
// HEADER  | framing only: send A5 and wait for done
// TRAILER | framing only: send word count and wait for done
module debug_tx_sequencer
  import debug_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  debug_tx_sequencer_if.master bus
);
  state_t                state;
  logic                  ser_load;
  logic                  ser_adv;
  logic                  ser_last;
  logic [BYTE_WIDTH-1:0] ser_byte;

  // Pop is combinational on empty so the FIFO is never read while empty.
  assign bus.o_fifo_rd_en = (state == S_POP) && !bus.i_fifo_empty;
  assign ser_load         = bus.o_fifo_rd_en;
  assign ser_adv          = (state == S_WAIT) && bus.i_tx_done && !ser_last;

  debug_word_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (ser_load),
    .i_advance (ser_adv),
    .i_word    (bus.i_fifo_data),
    .o_byte    (ser_byte),
    .o_last    (ser_last)
  );

`ifdef DEBUG_TX_FRAMING_EN
  logic [7:0] word_cnt;

  assign bus.o_tx_data = (state == S_HEADER)  ? FRAME_HEADER :
                         (state == S_TRAILER) ? word_cnt     : ser_byte;
`else
  assign bus.o_tx_data = ser_byte;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= S_IDLE;
      bus.o_tx_start <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
`ifdef DEBUG_TX_FRAMING_EN
      word_cnt       <= '0;
`endif
    end else begin
      bus.o_tx_start <= 1'b0;
      o_done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_busy <= 1'b1;
`ifdef DEBUG_TX_FRAMING_EN
            state          <= S_HEADER;
            bus.o_tx_start <= 1'b1;
`else
            state <= S_POP;
`endif
          end
        end
        S_POP: begin
          if (!bus.i_fifo_empty) begin
            state          <= S_SEND;
            bus.o_tx_start <= 1'b1;
`ifdef DEBUG_TX_FRAMING_EN
            word_cnt       <= word_cnt + 8'd1;
`endif
          end else begin
`ifdef DEBUG_TX_FRAMING_EN
            state          <= S_TRAILER;
            bus.o_tx_start <= 1'b1;
`else
            state  <= S_DONE;
            o_done <= 1'b1;
`endif
          end
        end
        S_SEND: state <= S_WAIT;
        S_WAIT: begin
          if (bus.i_tx_done) begin
            if (ser_last) begin
              state <= S_POP;
            end else begin
              state          <= S_SEND;
              bus.o_tx_start <= 1'b1;
            end
          end
        end
`ifdef DEBUG_TX_FRAMING_EN
        // A done coinciding with our own start strobe cannot belong to this byte.
        S_HEADER: begin
          if (bus.i_tx_done && !bus.o_tx_start) state <= S_POP;
        end
        S_TRAILER: begin
          if (bus.i_tx_done && !bus.o_tx_start) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
`ifdef DEBUG_TX_FRAMING_EN
          word_cnt <= '0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_tx_sequencer.sv
// Self-checking bench for debug_tx_sequencer: FIFO and UART models plus a byte-stream reference.
// Honours DEBUG_TX_FRAMING_EN to expect the framed stream.
module tb_debug_tx_sequencer;
  localparam int DW = 32;
`ifdef DEBUG_TX_FRAMING_EN
  localparam bit FRAMING = 1'b1;
`else
  localparam bit FRAMING = 1'b0;
`endif

  typedef struct {
    logic [7:0] b;
    int         gap;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_reset;
  logic i_start;
  logic o_busy;
  logic o_done;

  debug_tx_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  debug_tx_sequencer #(.DATA_WIDTH(DW), .BYTE_WIDTH(8)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (i_start),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  exp_t        exp_q[$];
  logic [31:0] fifo_q[$];
  logic [31:0] model_words[$];
  logic [31:0] mid_q[$];

  int n_checks = 0, n_fail = 0;
  int ref_cyc = 0, tx_count = 0, rd_cnt = 0, done_cnt = 0, pending = 0, dly = 3;
  bit outstanding = 0, noise_en = 0, stretch_next = 0, start_req = 0;
  logic [7:0] last_byte = 8'h00;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void upd_fifo();
    bus.i_fifo_empty = (fifo_q.size() == 0);
    bus.i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endfunction

  // Gap = cycles from i_start or the previous real done to this byte's start strobe.
  function automatic void add_word(input logic [31:0] w);
    exp_t e;
    for (int b = 0; b < DW / 8; b++) begin
      e.b   = w[8*b +: 8];
      e.gap = (b == 0) ? 2 : 1;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void build_exp();
    exp_t e;
    int   nw;
    nw = model_words.size() + mid_q.size();
    if (FRAMING) begin
      e.b = 8'hA5; e.gap = 1; exp_q.push_back(e);
    end
    foreach (model_words[i]) add_word(model_words[i]);
    foreach (mid_q[i]) add_word(mid_q[i]);
    if (FRAMING) begin
      e.b = 8'(nw % 256); e.gap = 2; exp_q.push_back(e);
    end
  endfunction

  function automatic void load_words(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      model_words.push_back(w);
      fifo_q.push_back(w);
    end
    upd_fifo();
  endfunction

  // FIFO pop side, UART TX responder and output monitor.
  initial begin : env
    bit   rd, st, rst_seen, busy_seen, done_seen;
    exp_t e;
    forever begin
      @(negedge i_clk);
      rd        = bus.o_fifo_rd_en;
      st        = bus.o_tx_start;
      rst_seen  = i_reset;
      busy_seen = o_busy;
      done_seen = o_done;
      if (!rst_seen) begin
        if (rd) begin
          rd_cnt++;
          chk_eq("rd_en_while_empty", 32'(bus.i_fifo_empty), 32'd0);
        end
        if (outstanding && !st) chk_eq("tx_data_hold", bus.o_tx_data, last_byte);
        if (st) begin
          chk_eq("single_outstanding", 32'(outstanding), 32'd0);
          if (exp_q.size() == 0) begin
            chk_eq("tx_start_unexpected", exp_q.size(), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk_eq("tx_byte", bus.o_tx_data, e.b);
            chk_eq("tx_gap", cyc - ref_cyc, e.gap);
          end
          tx_count++;
          outstanding = 1'b1;
          last_byte   = bus.o_tx_data;
        end
        if (done_seen) begin
          done_cnt++;
          chk_eq("done_gap", cyc - ref_cyc, FRAMING ? 32'd1 : 32'd2);
        end
      end

      @(posedge i_clk);
      #1;
      if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
      bus.i_tx_done = 1'b0;
      if (rst_seen) begin
        pending      = 0;
        outstanding  = 1'b0;
        stretch_next = 1'b0;
      end else begin
        // A stretched done lands in SEND/POP/DONE, where it must be ignored.
        if (stretch_next) begin
          bus.i_tx_done = 1'b1;
          stretch_next  = 1'b0;
        end
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            bus.i_tx_done = 1'b1;
            outstanding   = 1'b0;
            ref_cyc       = cyc;
            stretch_next  = noise_en;
          end
        end
        if (st) pending = dly - 1;
        else if (noise_en && !busy_seen && pending == 0 && $urandom_range(0, 3) == 0)
          bus.i_tx_done = 1'b1;
      end
      i_start = 1'b0;
      if (start_req) begin
        i_start   = 1'b1;
        start_req = 1'b0;
        ref_cyc   = cyc;
      end else if (noise_en && busy_seen && !done_seen && !rst_seen && $urandom_range(0, 2) == 0) begin
        i_start = 1'b1;
      end
      upd_fifo();
    end
  end

  task automatic run_dump(input int d, input bit nz);
    int t, c0, nw;
    nw = model_words.size() + mid_q.size();
    build_exp();
    dly      = d;
    noise_en = nz;
    rd_cnt   = 0;
    done_cnt = 0;
    @(negedge i_clk); #2;
    start_req = 1'b1;
    if (mid_q.size() > 0) begin
      c0 = tx_count;
      t  = 0;
      while (tx_count == c0 && t < 1000) begin
        @(negedge i_clk); #2;
        t++;
      end
      chk_eq("mid_push_wait", 32'(tx_count != c0), 32'd1);
      foreach (mid_q[i]) fifo_q.push_back(mid_q[i]);
      upd_fifo();
    end
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge i_clk); #2;
      t++;
    end
    chk_eq("dump_done_seen", 32'(done_cnt != 0), 32'd1);
    repeat (2) @(negedge i_clk);
    #2;
    chk_eq("done_pulses", done_cnt, 32'd1);
    chk_eq("busy_after", 32'(o_busy), 32'd0);
    chk_eq("bytes_left", exp_q.size(), 32'd0);
    chk_eq("rd_en_count", rd_cnt, nw);
    chk_eq("fifo_left", fifo_q.size(), 32'd0);
    noise_en = 1'b0;
    exp_q.delete();
    model_words.delete();
    mid_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_eq({tag, "_rd_en"}, 32'(bus.o_fifo_rd_en), 32'd0);
    chk_eq({tag, "_tx_start"}, 32'(bus.o_tx_start), 32'd0);
    chk_eq({tag, "_tx_data"}, bus.o_tx_data, 32'h00);
    chk_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
    chk_eq({tag, "_done"}, 32'(o_done), 32'd0);
  endtask

  initial begin : main
    int t, c0, nw;
    logic [31:0] w1;
    i_reset = 1'b1;
    i_start = 1'b0;
    bus.i_tx_done = 1'b0;
    upd_fifo();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk_reset_outputs("reset");
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);

    // Single word, LSB first.
    model_words.push_back(32'h11223344);
    fifo_q.push_back(32'h11223344);
    upd_fifo();
    run_dump(3, 1'b0);

    // Two words, slow UART.
    model_words.push_back(32'hDEADBEEF);
    model_words.push_back(32'h01020304);
    fifo_q.push_back(32'hDEADBEEF);
    fifo_q.push_back(32'h01020304);
    upd_fifo();
    run_dump(10, 1'b0);

    // Empty FIFO.
    run_dump(3, 1'b0);

    // Same single word with spurious start/done activity.
    model_words.push_back(32'h11223344);
    fifo_q.push_back(32'h11223344);
    upd_fifo();
    run_dump(3, 1'b1);

    // Reset while waiting on the second byte, then resume from the next word.
    load_words(2);
    w1 = model_words[1];
    build_exp();
    dly = 10;
    @(negedge i_clk); #2;
    c0 = tx_count;
    start_req = 1'b1;
    t = 0;
    while (tx_count < c0 + 2 && t < 1000) begin
      @(negedge i_clk); #2;
      t++;
    end
    chk_eq("reset_test_bytes", tx_count - c0, 32'd2);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk); #2;
    chk_reset_outputs("mid_reset");
    chk_eq("fifo_after_reset", fifo_q.size(), 32'd1);
    exp_q.delete();
    model_words.delete();
    model_words.push_back(w1);
    run_dump(4, 1'b0);

    // Three queued words.
    load_words(3);
    run_dump(4, 1'b0);

    // Randomized dumps, some with words arriving mid-dump.
    for (int it = 0; it < 8; it++) begin
      nw = $urandom_range(0, 3);
      load_words(nw);
      if (nw > 0) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) mid_q.push_back($urandom);
      end
      run_dump($urandom_range(2, 6), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
